// File: rtl/clock_div_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_div_controller_if
// Description : Divisor configuration port of the clock divider controller.
//               The master offers a divisor with cfg_valid/cfg_divisor. The
//               slave answers with cfg_ready, and pulses cfg_err for one cycle
//               when it drops an illegal divisor.
//   cfg_valid    master->slave  new divisor offered
//   cfg_divisor  master->slave  requested divisor (WIDTH bits)
//   cfg_ready    slave->master  a divisor can be accepted this cycle
//   cfg_err      slave->master  1-cycle pulse, offered divisor was rejected
// Revision    : 1.0  initial release
// ============================================================================
interface clock_div_controller_if #(
  parameter int WIDTH = 28
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_divisor;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_divisor,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_divisor,
    output cfg_ready,
    output cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/clock_div_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_div_controller
// Description : Run/stop and reconfiguration controller for the board clock
//               divider. It owns the divide counter and produces a registered
//               divided square wave plus a one-cycle tick at the start of each
//               period. New divisors only take effect at a period boundary, or
//               when the divider stops, so clock_out never has a runt pulse.
//   clock_in        in   single clock, all logic on posedge
//   reset           in   synchronous, active-high reset
//   enable          in   1 = run the divider, 0 = stop (level)
//   cfg             if   divisor configuration port (slave side)
//   clock_out       out  divided clock, high for floor(D/2) cycles per period
//   tick            out  1-cycle pulse at the start of each period
//   active_divisor  out  divisor currently in use
//   period_count    out  completed periods since the last divisor apply
// Revision    : 1.0  initial release
// ============================================================================
module clock_div_controller #(
  parameter int               WIDTH           = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = WIDTH'(50_000_000),
  parameter logic [WIDTH-1:0] MIN_DIVISOR     = WIDTH'(2)
) (
  input  wire logic               clock_in,
  input  wire logic               reset,
  input  wire logic               enable,
  clock_div_controller_if.slave   cfg,
  output logic                    clock_out,
  output logic                    tick,
  output logic [WIDTH-1:0]        active_divisor,
  output logic [15:0]             period_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_pending;
  logic             r_clock_out;
  logic             r_tick;
  logic             r_cfg_err;
  logic [15:0]      r_period_count;

  logic             w_ready;
  logic             w_legal;
  logic             w_xfer;
  logic             w_accept;
  logic             w_running;
  logic             w_drive;
  logic             w_wrap;
  logic [WIDTH-1:0] w_half;

  // Only one divisor can wait for the boundary, so the port closes while one
  // is pending; it is open at all other times.
  assign w_ready   = (r_state != ST_PENDING);
  assign w_legal   = (cfg.cfg_divisor >= MIN_DIVISOR);
  assign w_xfer    = cfg.cfg_valid && w_ready;
  assign w_accept  = w_xfer && w_legal;
  assign w_running = (r_state != ST_IDLE);
  // Outputs are forced low in the cycle enable drops, so the divider is
  // already silent in the first IDLE cycle.
  assign w_drive   = w_running && enable;
  assign w_wrap    = (r_counter == (r_active - WIDTH'(1)));
  assign w_half    = r_active >> 1;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_counter      <= '0;
      r_active       <= DEFAULT_DIVISOR;
      r_pending      <= '0;
      r_clock_out    <= 1'b0;
      r_tick         <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_period_count <= '0;
    end else begin
      r_clock_out <= w_drive && (r_counter < w_half);
      r_tick      <= w_drive && (r_counter == '0);
      r_cfg_err   <= w_xfer && !w_legal;

      case (r_state)
        ST_IDLE: begin
          r_counter <= '0;
          // Applied before the first RUN cycle, so the first period already
          // uses the new divisor when enable rises in the same cycle.
          if (w_accept) begin
            r_active       <= cfg.cfg_divisor;
            r_period_count <= '0;
          end
          if (enable) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!enable) begin
            r_state   <= ST_IDLE;
            r_counter <= '0;
            // Stopping ends the period anyway, so a divisor offered now can
            // take effect immediately.
            if (w_accept) begin
              r_active       <= cfg.cfg_divisor;
              r_period_count <= '0;
            end
          end else begin
            r_counter <= w_wrap ? '0 : (r_counter + WIDTH'(1));
            if (w_wrap) begin
              r_period_count <= r_period_count + 16'd1;
            end
            // A transfer coinciding with a wrap waits for the following wrap,
            // because this boundary has already been consumed.
            if (w_accept) begin
              r_pending <= cfg.cfg_divisor;
              r_state   <= ST_PENDING;
            end
          end
        end

        ST_PENDING: begin
          if (!enable || w_wrap) begin
            r_active       <= r_pending;
            r_period_count <= '0;
            r_counter      <= '0;
            r_state        <= enable ? ST_RUN : ST_IDLE;
          end else begin
            r_counter <= r_counter + WIDTH'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_counter <= '0;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_err   = r_cfg_err;
  assign clock_out     = r_clock_out;
  assign tick          = r_tick;
  assign active_divisor = r_active;
  assign period_count  = r_period_count;

endmodule
`default_nettype wire

// File: tb/tb_clock_div_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_div_controller
// Description : Self-checking bench for clock_div_controller, built with a
//               divisor of 10 at reset. Stimulus queues the expected
//               per-period results and the cfg_err answer for every offer; a
//               monitor thread measures each period between ticks and checks
//               it against the queued expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_clock_div_controller;

  localparam int WIDTH = 28;

  typedef struct {
    int len;   // expected cycles since previous tick, 0 = not measured
    int high;  // expected clock_out high cycles in that period
    int div;   // expected active_divisor at the tick
    int pc;    // expected period_count at the tick
  } tick_exp_t;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             clock_out;
  logic             tick;
  logic [WIDTH-1:0] active_divisor;
  logic [15:0]      period_count;

  clock_div_controller_if #(.WIDTH(WIDTH)) bus ();

  clock_div_controller #(
    .WIDTH          (WIDTH),
    .DEFAULT_DIVISOR(28'd10),
    .MIN_DIVISOR    (28'd2)
  ) dut (
    .clock_in      (clk),
    .reset         (reset),
    .enable        (enable),
    .cfg           (bus),
    .clock_out     (clock_out),
    .tick          (tick),
    .active_divisor(active_divisor),
    .period_count  (period_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_tests = 0;
  int        n_fail  = 0;
  tick_exp_t q_tick[$];
  int        q_err[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_tick(input int len, input int high, input int div, input int pc);
    tick_exp_t e;
    e.len  = len;
    e.high = high;
    e.div  = div;
    e.pc   = pc;
    q_tick.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle offer; the required cfg_err answer is queued for the monitor.
  task automatic offer(input int div, input int exp_err);
    bus.cfg_valid   = 1'b1;
    bus.cfg_divisor = WIDTH'(div);
    q_err.push_back(exp_err);
    cycles(1);
    bus.cfg_valid   = 1'b0;
  endtask

  task automatic wait_ticks();
    int budget = 0;
    while (q_tick.size() != 0 && budget < 400) begin
      @(posedge clk);
      budget++;
    end
    if (q_tick.size() != 0) begin
      check("tick_timeout_pending", q_tick.size(), 0);
      q_tick.delete();
    end
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_clock_out"}, clock_out, 0);
    check({tag, "_tick"}, tick, 0);
    check({tag, "_cfg_ready"}, bus.cfg_ready, 1);
    check({tag, "_cfg_err"}, bus.cfg_err, 0);
    check({tag, "_active_divisor"}, active_divisor, 10);
    check({tag, "_period_count"}, period_count, 0);
  endtask

  task automatic monitor();
    int        len  = 0;
    int        high = 0;
    logic      offered;
    tick_exp_t e;
    forever begin
      @(posedge clk);
      offered = bus.cfg_valid;
      @(negedge clk);
      if (offered) begin
        if (q_err.size() != 0) begin
          check("cfg_err_response", bus.cfg_err, q_err.pop_front());
        end else begin
          check("cfg_err_unqueued_offer", q_err.size(), 1);
        end
      end else if (bus.cfg_err) begin
        check("cfg_err_spurious", bus.cfg_err, 0);
      end
      if (tick) begin
        if (q_tick.size() == 0) begin
          check("tick_unexpected", tick, 0);
        end else begin
          e = q_tick.pop_front();
          if (e.len != 0) begin
            check("period_length", len, e.len);
            check("period_high_time", high, e.high);
          end
          check("tick_clock_out_rise", clock_out, 1);
          check("tick_active_divisor", active_divisor, e.div);
          check("tick_period_count", period_count, e.pc);
        end
        len  = 1;
        high = 1;
        if (clock_out !== 1'b1) high = 0;
      end else begin
        len++;
        if (clock_out === 1'b1) high++;
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.cfg_divisor = '0;
    fork
      monitor();
    join_none
    @(posedge clk);
    #1;

    // 1: reset values, then free running with divisor 10.
    cycles(3);
    check_reset_values("reset");
    push_tick(0, 0, 10, 0);
    push_tick(10, 5, 10, 1);
    push_tick(10, 5, 10, 2);
    push_tick(10, 5, 10, 3);
    reset  = 1'b0;
    enable = 1'b1;
    wait_ticks();

    // 3: illegal divisors 1 and 0 are dropped with one cfg_err pulse each.
    push_tick(10, 5, 10, 4);
    push_tick(10, 5, 10, 5);
    offer(1, 1);
    check("illegal1_cfg_ready", bus.cfg_ready, 1);
    cycles(1);
    offer(0, 1);
    check("illegal0_cfg_ready", bus.cfg_ready, 1);
    check("illegal_active_divisor", active_divisor, 10);
    wait_ticks();

    // 2: divisor 4 offered mid-period waits for the 10-cycle period to end.
    push_tick(10, 5, 4, 0);
    push_tick(4, 2, 4, 1);
    push_tick(4, 2, 4, 2);
    offer(4, 0);
    check("pending4_cfg_ready", bus.cfg_ready, 0);
    check("pending4_active_unchanged", active_divisor, 10);
    wait_ticks();
    check("applied4_cfg_ready", bus.cfg_ready, 1);

    // 4: stop, then offer 7 together with enable: first period is 7 cycles.
    enable = 1'b0;
    cycles(1);
    check("stop_clock_out", clock_out, 0);
    check("stop_tick", tick, 0);
    cycles(2);
    push_tick(0, 0, 7, 0);
    push_tick(7, 3, 7, 1);
    push_tick(7, 3, 7, 2);
    enable = 1'b1;
    offer(7, 0);
    check("idle_apply7_active", active_divisor, 7);
    wait_ticks();

    // 5: divisor 6 pending when enable drops is applied on the way to IDLE.
    offer(6, 0);
    check("pending6_cfg_ready", bus.cfg_ready, 0);
    enable = 1'b0;
    cycles(1);
    check("stop_pending_clock_out", clock_out, 0);
    check("stop_pending_active", active_divisor, 6);
    check("stop_pending_cfg_ready", bus.cfg_ready, 1);
    check("stop_pending_period_count", period_count, 0);
    cycles(2);
    push_tick(0, 0, 6, 0);
    push_tick(6, 3, 6, 1);
    push_tick(6, 3, 6, 2);
    enable = 1'b1;
    wait_ticks();

    // 6: reset while a divisor is pending discards it.
    offer(5, 0);
    check("pending5_cfg_ready", bus.cfg_ready, 0);
    reset = 1'b1;
    cycles(1);
    check_reset_values("reset_pending");
    push_tick(0, 0, 10, 0);
    push_tick(10, 5, 10, 1);
    reset = 1'b0;
    wait_ticks();

    // 6: reset in the middle of a high phase.
    check("mid_period_clock_out_high", clock_out, 1);
    reset  = 1'b1;
    enable = 1'b0;
    cycles(1);
    check_reset_values("reset_mid_period");
    reset = 1'b0;
    cycles(3);

    check("leftover_tick_expectations", q_tick.size(), 0);
    check("leftover_err_expectations", q_err.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
